output_port_bank: RTL and testbench
===================================

OUTPUT_PORT_BANK -- requirements
Module: output_port_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of each output channel and of w_bus.
REQ-002 Parameter CHANNELS, default 4, range 2..16, SHALL set the number of independent output registers.
REQ-003 Parameter DWELL, default 1000, minimum 1, SHALL set the number of clk cycles each channel is held on the scan output.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 lo_n  input  1  SHALL be the active-low load strobe.
REQ-007 sel  input  $clog2(CHANNELS)  SHALL select the channel to load.
REQ-008 w_bus  input  WIDTH  SHALL be the data to load.
REQ-009 out_regs  output  CHANNELS*WIDTH  SHALL present all channel registers flattened, with channel k at bits [k*WIDTH +: WIDTH].
REQ-010 upd  output  CHANNELS  SHALL give a one-cycle pulse per channel, asserted the cycle after that channel loads.
REQ-011 scan_data  output  WIDTH  SHALL present the currently scanned channel value.
REQ-012 scan_idx  output  $clog2(CHANNELS)  SHALL present the index of the channel on scan_data.

Function
REQ-013 When lo_n=0 and sel<CHANNELS, channel[sel] SHALL capture w_bus at the clock edge; it is visible on out_regs the following cycle.
REQ-014 When lo_n=1, every channel SHALL hold its value (no clear-on-idle).
REQ-015 When lo_n=0 and sel>=CHANNELS, no channel SHALL change and upd SHALL stay 0.
REQ-016 upd[sel] SHALL assert for exactly one cycle after each accepted load, including a reload of an identical value; back-to-back loads SHALL give back-to-back pulses.
REQ-017 The dwell counter SHALL count 0..DWELL-1; on reaching DWELL-1 it SHALL wrap to 0 and scan_idx SHALL advance by one.
REQ-018 scan_idx SHALL wrap from CHANNELS-1 to 0.
REQ-019 scan_data SHALL be registered: scan_data = channel[scan_idx] as sampled on the previous edge (one-cycle latency).
REQ-020 When a load and a scan refer to the same channel in the same cycle, scan_data SHALL show the old value that cycle and the new value the next cycle.
REQ-021 When DWELL=1, scan_idx SHALL advance every cycle.

Reset
REQ-022 While rst=1, all channels, out_regs, upd, scan_data, scan_idx and the dwell counter SHALL be 0 at the next edge.
REQ-023 rst SHALL take priority over a simultaneous load; no upd SHALL pulse for that load.
REQ-024 Reset mid-scan SHALL restart the scan at channel 0 with a zeroed dwell counter.

Configuration
REQ-025 With OUT_PORT_SCAN_EN defined, the dwell counter, scan_idx and scan_data logic SHALL be built as specified.
REQ-026 Without OUT_PORT_SCAN_EN, scan_data and scan_idx SHALL be tied to 0, the dwell counter SHALL not be instantiated, and REQ-013..REQ-016 SHALL behave identically.

Structure
REQ-027 A shared package SHALL hold the default WIDTH, CHANNELS and DWELL constants and a clog2-based index-width helper.
REQ-028 The scan logic SHALL be one sub-module, out_scan_ctrl (dwell counter plus index counter), instantiated only under OUT_PORT_SCAN_EN.

Verification
REQ-029 Reset then lo_n=0, sel=2, w_bus=8'hA5 -> out_regs[23:16]=8'hA5 next cycle, upd=4'b0100 for one cycle, other channels stay 0.
REQ-030 Load 8'h3C into ch1, then lo_n=1 for 10 cycles -> ch1 holds 8'h3C throughout, no upd pulses.
REQ-031 CHANNELS=3, sel=3, lo_n=0, w_bus=8'hFF -> no channel changes, upd=0.
REQ-032 DWELL=4, channels loaded with 8'h11/22/33/44 -> scan_idx sequence 0,1,2,3,0 every 4 cycles; scan_data lags scan_idx by one cycle.
REQ-033 rst=1 together with lo_n=0, sel=0, w_bus=8'h77, during mid-scan at scan_idx=2 -> all outputs 0, scan restarts at 0, no upd.
REQ-034 Build without OUT_PORT_SCAN_EN, rerun REQ-029..031 -> same results, with scan_data=0 and scan_idx=0 constantly.

Source files
------------

// File: rtl/output_port_bank_pkg.sv
// output_port_bank_pkg
// Shared defaults for the output port bank and its scan controller, plus
// the helper that sizes index/counter fields.
//   DEF_WIDTH    : default channel data width
//   DEF_CHANNELS : default number of output channels
//   DEF_DWELL    : default number of cycles each channel stays on the scan output
//   idx_width(n) : bits needed to hold 0..n-1, never less than 1
package output_port_bank_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DWELL    = 1000;

  // $clog2(1) is 0; a counter that only ever holds 0 still needs one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/output_port_bank_scan_ctrl.sv
// out_scan_ctrl
// Dwell counter plus scan index counter. The index holds for DWELL cycles,
// then advances by one, wrapping from CHANNELS-1 back to 0.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (index and dwell count to 0)
//   scan_idx_o : channel currently selected for the scan output
module out_scan_ctrl
  import output_port_bank_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DWELL    = DEF_DWELL
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [$clog2(CHANNELS)-1:0] scan_idx_o
);

  localparam int IW = $clog2(CHANNELS);
  localparam int CW = idx_width(DWELL);

  logic [CW-1:0] dwell_q, dwell_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          dwell_end;

  assign dwell_end = (int'(dwell_q) == DWELL - 1);

  always_comb begin
    dwell_d = dwell_q + CW'(1);
    idx_d   = idx_q;
    if (dwell_end) begin
      dwell_d = '0;
      // CHANNELS need not be a power of two, so wrap explicitly.
      idx_d   = (int'(idx_q) == CHANNELS - 1) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      idx_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
    end
  end

  assign scan_idx_o = idx_q;

endmodule

// File: rtl/output_port_bank.sv
// output_port_bank
// Bank of CHANNELS independently loadable output registers with a per-channel
// update pulse and an optional time-multiplexed scan output.
// Build option: define OUT_PORT_SCAN_EN to build the scan logic
// (out_scan_ctrl plus the registered scan_data). Without it scan_data and
// scan_idx are tied to 0.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   lo_n      : active-low load strobe
//   sel       : channel to load; values >= CHANNELS are ignored
//   w_bus     : load data
//   out_regs  : all channels flattened, channel k at [k*WIDTH +: WIDTH]
//   upd       : one-cycle pulse per channel, the cycle after it loads
//   scan_data : value of channel scan_idx as sampled on the previous edge
//   scan_idx  : channel currently scanned
// Handshake: there is no back-pressure. A load is accepted on any rising edge
// where lo_n=0, sel<CHANNELS and rst=0; it is never stalled or queued.
module output_port_bank
  import output_port_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DWELL    = DEF_DWELL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lo_n,
  input  logic [$clog2(CHANNELS)-1:0] sel,
  input  logic [WIDTH-1:0]            w_bus,
  output logic [CHANNELS*WIDTH-1:0]   out_regs,
  output logic [CHANNELS-1:0]         upd,
  output logic [WIDTH-1:0]            scan_data,
  output logic [$clog2(CHANNELS)-1:0] scan_idx
);

  localparam int IW = $clog2(CHANNELS);

  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("output_port_bank: CHANNELS must be 2..16");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("output_port_bank: DWELL must be at least 1");
  end

  logic [CHANNELS-1:0][WIDTH-1:0] chan_q, chan_d;
  logic [CHANNELS-1:0]            upd_q, upd_d;
  logic                           load_ok;

  // Out-of-range selects (only possible when CHANNELS is not a power of two)
  // are dropped entirely: no data change and no update pulse.
  assign load_ok = !lo_n && (int'(sel) < CHANNELS);

  always_comb begin
    chan_d = chan_q;
    upd_d  = '0;
    if (load_ok) begin
      chan_d[sel] = w_bus;
      upd_d[sel]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_q <= '0;
      upd_q  <= '0;
    end else begin
      chan_q <= chan_d;
      upd_q  <= upd_d;
    end
  end

  assign out_regs = chan_q;
  assign upd      = upd_q;

`ifdef OUT_PORT_SCAN_EN
  logic [IW-1:0]    scan_idx_w;
  logic [WIDTH-1:0] scan_data_q;

  out_scan_ctrl #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .scan_idx_o (scan_idx_w)
  );

  // Samples the pre-edge register, so a load to the scanned channel shows
  // up on scan_data one cycle after it appears on out_regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_data_q <= '0;
    end else begin
      scan_data_q <= chan_q[scan_idx_w];
    end
  end

  assign scan_data = scan_data_q;
  assign scan_idx  = scan_idx_w;
`else
  assign scan_data = '0;
  assign scan_idx  = '0;
`endif

endmodule

// File: tb/tb_output_port_bank.sv
// tb_output_port_bank
// Two instances: a 4-channel bank with DWELL=4 and a 3-channel bank with
// DWELL=2 (exercises out-of-range selects). A reference model computes the
// expected outputs for each edge, pushes them to a queue, and they are popped
// and compared #1 after that edge.
module tb_output_port_bank;

`ifdef OUT_PORT_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int DW  = 4;
  localparam int CH3 = 3;
  localparam int DW3 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // ---------------- DUT A: 4 channels ----------------
  logic           lo_n  = 1'b1;
  logic [1:0]     sel   = '0;
  logic [W-1:0]   w_bus = '0;
  logic [CH*W-1:0] out_regs;
  logic [CH-1:0]  upd;
  logic [W-1:0]   scan_data;
  logic [1:0]     scan_idx;

  output_port_bank #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .lo_n      (lo_n),
    .sel       (sel),
    .w_bus     (w_bus),
    .out_regs  (out_regs),
    .upd       (upd),
    .scan_data (scan_data),
    .scan_idx  (scan_idx)
  );

  // ---------------- DUT B: 3 channels ----------------
  logic             lo_n3  = 1'b1;
  logic [1:0]       sel3   = '0;
  logic [W-1:0]     w_bus3 = '0;
  logic [CH3*W-1:0] out_regs3;
  logic [CH3-1:0]   upd3;
  logic [W-1:0]     scan_data3;
  logic [1:0]       scan_idx3;

  output_port_bank #(.WIDTH(W), .CHANNELS(CH3), .DWELL(DW3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .lo_n      (lo_n3),
    .sel       (sel3),
    .w_bus     (w_bus3),
    .out_regs  (out_regs3),
    .upd       (upd3),
    .scan_data (scan_data3),
    .scan_idx  (scan_idx3)
  );

  // ---------------- scoreboard ----------------
  // A: {out_regs[31:0], upd[3:0], scan_data[7:0], scan_idx[1:0]}
  logic [45:0] exp_q[$];
  // B: {out_regs[23:0], upd[2:0], scan_data[7:0], scan_idx[1:0]}
  logic [36:0] exp3_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (values currently held by the DUTs).
  logic [W-1:0] m_chan[CH];
  logic [W-1:0] m_chan3[CH3];
  int           m_t;   // non-reset edges since the last reset edge

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Which channel is on the scan output after t edges of free-running scan.
  function automatic int scan_pos(input int t, input int dwell, input int chans);
    return (t / dwell) % chans;
  endfunction

  // One clock: predict, push, clock, pop, compare.
  task automatic step();
    logic [W-1:0]   nc[CH];
    logic [W-1:0]   nc3[CH3];
    logic [CH-1:0]  nu;
    logic [CH3-1:0] nu3;
    logic [W-1:0]   nd, nd3;
    logic [1:0]     ni, ni3;
    int             nt;
    logic [45:0]    e;
    logic [36:0]    e3;

    nc  = m_chan;
    nc3 = m_chan3;
    nu  = '0;
    nu3 = '0;
    if (rst) begin
      foreach (nc[k])  nc[k]  = '0;
      foreach (nc3[k]) nc3[k] = '0;
      nd = '0; nd3 = '0; ni = '0; ni3 = '0;
      nt = 0;
    end else begin
      if (!lo_n) begin
        nc[sel] = w_bus;
        nu[sel] = 1'b1;
      end
      if (!lo_n3 && int'(sel3) < CH3) begin
        nc3[sel3] = w_bus3;
        nu3[sel3] = 1'b1;
      end
      nd  = m_chan[scan_pos(m_t, DW, CH)];
      nd3 = m_chan3[scan_pos(m_t, DW3, CH3)];
      nt  = m_t + 1;
      ni  = 2'(scan_pos(nt, DW, CH));
      ni3 = 2'(scan_pos(nt, DW3, CH3));
    end
    if (!SCAN) begin
      nd = '0; nd3 = '0; ni = '0; ni3 = '0;
    end

    exp_q.push_back({nc[3], nc[2], nc[1], nc[0], nu, nd, ni});
    exp3_q.push_back({nc3[2], nc3[1], nc3[0], nu3, nd3, ni3});
    m_chan  = nc;
    m_chan3 = nc3;
    m_t     = nt;

    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    e3 = exp3_q.pop_front();
    check("a_out_regs",  out_regs,   e[45:14]);
    check("a_upd",       upd,        e[13:10]);
    check("a_scan_data", scan_data,  e[9:2]);
    check("a_scan_idx",  scan_idx,   e[1:0]);
    check("b_out_regs",  out_regs3,  e3[36:13]);
    check("b_upd",       upd3,       e3[12:10]);
    check("b_scan_data", scan_data3, e3[9:2]);
    check("b_scan_idx",  scan_idx3,  e3[1:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    lo_n = 1'b1; lo_n3 = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_a(input logic [1:0] s, input logic [W-1:0] d);
    lo_n = 1'b0; sel = s; w_bus = d;
    step();
    lo_n = 1'b1;
  endtask

  task automatic load_b(input logic [1:0] s, input logic [W-1:0] d);
    lo_n3 = 1'b0; sel3 = s; w_bus3 = d;
    step();
    lo_n3 = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    foreach (m_chan[k])  m_chan[k]  = 'x;
    foreach (m_chan3[k]) m_chan3[k] = 'x;
    m_t = 0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Load 0xA5 into channel 2, then one idle cycle to see the pulse end
    load_a(2'd2, 8'hA5);
    idle(1);

    // Load 0x3C into channel 1 and hold for 10 cycles
    load_a(2'd1, 8'h3C);
    idle(10);

    // Out-of-range select on the 3-channel bank, then a valid one
    load_b(2'd3, 8'hFF);
    load_b(2'd2, 8'h5A);
    load_b(2'd3, 8'hEE);

    // Back-to-back loads of all channels, then an identical reload
    lo_n = 1'b0; lo_n3 = 1'b0;
    for (int k = 0; k < CH; k++) begin
      sel = 2'(k); w_bus = 8'(8'h11 * (k + 1));
      sel3 = 2'(k); w_bus3 = 8'(8'h80 + k);
      step();
    end
    sel = 2'd3; w_bus = 8'h44;
    step();
    idle(24);

    // Reset mid-scan at scan index 2, together with a load
    for (int i = 0; i < 40 && scan_pos(m_t, DW, CH) != 2; i++) step();
    check("reached_idx2", 32'(scan_pos(m_t, DW, CH)), 32'd2);
    rst = 1'b1; lo_n = 1'b0; sel = 2'd0; w_bus = 8'h77;
    lo_n3 = 1'b0; sel3 = 2'd0; w_bus3 = 8'h77;
    step();
    rst = 1'b0;
    idle(6);

    // Random traffic on both banks
    for (int i = 0; i < 60; i++) begin
      lo_n   = 1'($urandom_range(0, 1));
      sel    = 2'($urandom_range(0, 3));
      w_bus  = 8'($urandom_range(0, 255));
      lo_n3  = 1'($urandom_range(0, 1));
      sel3   = 2'($urandom_range(0, 3));
      w_bus3 = 8'($urandom_range(0, 255));
      step();
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
